icnd2110_rx: RTL

- Receive-side counterpart of the icnd2110 driver: oversamples the spi_c/spi_d pair and deserializes it back into 16-bit PWM words tagged with chip and channel index.
- Detects frame boundaries from the idle gap and flags malformed frames.
- Used as an on-chip loopback checker and as a sniffer on a spare pin pair, so the LED chain can be checked without a logic analyser.

---
 rtl/icnd2110_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 54 +++++
 rtl/icnd2110_rx.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/icnd2110_pkg.sv
// Shared definitions for the icnd2110 LED driver family.
// Holds the word/channel defaults that the driver and the receiver agree on,
// plus the receiver's frame-tracking state encoding.
package icnd2110_pkg;

  localparam int ICND_WORD_BITS   = 16;  // bits per PWM word, MSB first
  localparam int ICND_CHANNELS    = 16;  // words per chip per frame
  localparam int ICND_IDLE_CYCLES = 64;  // spi_c-low clk cycles that close a frame
  localparam int ICND_CHIP_BITS   = 8;   // width of chip index / chipcount

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for a full idle gap before trusting the wire
    ST_ARMED = 2'd1,  // gap seen, next rising edge starts a frame
    ST_RECV  = 2'd2   // inside a frame, shifting bits
  } rx_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings the asynchronous spi_c/spi_d pair into the clk domain.
// Both lines go through synchronizers of identical depth so the data bit
// seen alongside a clock rising edge is the one present at that edge.
//
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   spi_c_i   : raw serial clock
//   spi_d_i   : raw serial data
//   sync_c_o  : synchronized spi_c level, aligned with c_rise_o
//   sync_d_o  : synchronized spi_d, aligned with c_rise_o
//   c_rise_o  : one-cycle strobe for a rising edge of spi_c
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic spi_c_i,
  input  logic spi_d_i,
  output logic sync_c_o,
  output logic sync_d_o,
  output logic c_rise_o
);

  logic c_meta_q, c_sync_q, c_prev_q;
  logic d_meta_q, d_sync_q;
  logic c_rise_q, c_lvl_q, d_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_meta_q <= 1'b0;
      c_sync_q <= 1'b0;
      c_prev_q <= 1'b0;
      d_meta_q <= 1'b0;
      d_sync_q <= 1'b0;
      c_rise_q <= 1'b0;
      c_lvl_q  <= 1'b0;
      d_out_q  <= 1'b0;
    end else begin
      c_meta_q <= spi_c_i;
      c_sync_q <= c_meta_q;
      c_prev_q <= c_sync_q;
      d_meta_q <= spi_d_i;
      d_sync_q <= d_meta_q;
      // Edge strobe, level and data are all registered from the same
      // synchronizer stage so they line up in one cycle.
      c_rise_q <= c_sync_q & ~c_prev_q;
      c_lvl_q  <= c_sync_q;
      d_out_q  <= d_sync_q;
    end
  end

  assign sync_c_o = c_lvl_q;
  assign sync_d_o = d_out_q;
  assign c_rise_o = c_rise_q;

endmodule

// File: rtl/icnd2110_rx.sv
// Receiver for the icnd2110 serial LED stream. Oversamples spi_c/spi_d,
// finds frames from the idle gap, and rebuilds 16-bit PWM words tagged with
// their chip and channel position. Each frame is judged complete when it
// has no partial word and exactly chipcount*CHANNELS words.
//
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   spi_c, spi_d : serial clock/data from the driver (asynchronous)
//   chipcount    : expected chips per frame, captured at frame start
//   word_data    : last completed word
//   word_valid   : strobe qualifying word_data/chan_idx/chip_idx
//   chan_idx     : channel of the emitted word
//   chip_idx     : chip of the emitted word (0 = first on the wire)
//   frame_start  : pulse on the first bit of a frame
//   frame_end    : pulse when the idle gap closes a frame
//   frame_ok     : frame verdict, meaningful only with frame_end
//   busy         : high while a frame is being received
//
// Handshake: there is no back-pressure. word_valid, frame_start and
// frame_end are single-cycle strobes; a consumer must take them when seen.
module icnd2110_rx
  import icnd2110_pkg::*;
#(
  parameter int WORD_BITS   = ICND_WORD_BITS,
  parameter int CHANNELS    = ICND_CHANNELS,
  parameter int IDLE_CYCLES = ICND_IDLE_CYCLES,
  parameter int CHIP_BITS   = ICND_CHIP_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_c,
  input  logic                 spi_d,
  input  logic [CHIP_BITS-1:0] chipcount,
  output logic [WORD_BITS-1:0] word_data,
  output logic                 word_valid,
  output logic [3:0]           chan_idx,
  output logic [CHIP_BITS-1:0] chip_idx,
  output logic                 frame_start,
  output logic                 frame_end,
  output logic                 frame_ok,
  output logic                 busy
);

  localparam int BW = $clog2(WORD_BITS);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int TW = CHIP_BITS + 4;

  logic sync_c, sync_d, c_rise;

  spi_sync_edge u_sync (
    .clk      (clk),
    .rst      (rst),
    .spi_c_i  (spi_c),
    .spi_d_i  (spi_d),
    .sync_c_o (sync_c),
    .sync_d_o (sync_d),
    .c_rise_o (c_rise)
  );

  rx_state_e state_q, state_d;

  logic [IW-1:0]          idle_cnt_q, idle_cnt_d;
  logic [BW-1:0]          bit_cnt_q;
  logic [WORD_BITS-2:0]   shift_q;
  logic [WORD_BITS-1:0]   shift_nxt;
  logic [CHIP_BITS-1:0]   chipcount_q;
  logic [3:0]             pos_chan_q;
  logic [CHIP_BITS-1:0]   pos_chip_q;
  logic                   ovf_q;
  logic [WORD_BITS-1:0]   word_data_q;
  logic                   word_valid_q;
  logic [3:0]             chan_idx_q;
  logic [CHIP_BITS-1:0]   chip_idx_q;
  logic                   frame_start_q, frame_end_q, frame_ok_q;

  logic                   idle_hit;
  logic                   frame_begin, bit_en, frame_close;
  logic [TW-1:0]          words_seen, words_want;
  logic                   frame_good;

  // Idle counter: cleared by any sign of spi_c activity, saturating.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (c_rise || sync_c) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IW'(IDLE_CYCLES)) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  // A rising edge in the same cycle always beats the gap.
  assign idle_hit = (idle_cnt_q == IW'(IDLE_CYCLES)) && !c_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_begin = 1'b0;
    bit_en      = 1'b0;
    frame_close = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Edges are ignored until a full gap guarantees frame alignment.
        if (idle_hit) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (c_rise) begin
          frame_begin = 1'b1;
          bit_en      = 1'b1;
          state_d     = ST_RECV;
        end
      end
      ST_RECV: begin
        if (c_rise) begin
          bit_en = 1'b1;
        end else if (idle_hit) begin
          frame_close = 1'b1;
          state_d     = ST_ARMED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign shift_nxt  = {shift_q, sync_d};

  // pos_* always point at the next word, so together they count the
  // words received in this frame.
  assign words_seen = TW'(pos_chip_q) * TW'(CHANNELS) + TW'(pos_chan_q);
  assign words_want = TW'(chipcount_q) * TW'(CHANNELS);
  assign frame_good = (bit_cnt_q == '0) && !ovf_q && (chipcount_q != '0) &&
                      (words_seen == words_want);

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      chipcount_q   <= '0;
      pos_chan_q    <= '0;
      pos_chip_q    <= '0;
      ovf_q         <= 1'b0;
      word_data_q   <= '0;
      word_valid_q  <= 1'b0;
      chan_idx_q    <= '0;
      chip_idx_q    <= '0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_ok_q    <= 1'b0;
    end else begin
      idle_cnt_q    <= idle_cnt_d;
      word_valid_q  <= 1'b0;
      frame_start_q <= frame_begin;
      frame_end_q   <= frame_close;
      frame_ok_q    <= 1'b0;

      if (frame_begin) begin
        chipcount_q <= chipcount;
        pos_chan_q  <= '0;
        pos_chip_q  <= '0;
        ovf_q       <= 1'b0;
      end

      if (bit_en) begin
        shift_q <= shift_nxt[WORD_BITS-2:0];
        if (bit_cnt_q == BW'(WORD_BITS - 1)) begin
          bit_cnt_q    <= '0;
          word_data_q  <= shift_nxt;
          word_valid_q <= 1'b1;
          chan_idx_q   <= pos_chan_q;
          chip_idx_q   <= pos_chip_q;
          if (pos_chan_q == 4'(CHANNELS - 1)) begin
            pos_chan_q <= '0;
            // Chip index sticks at all-ones; the frame can no longer match.
            if (pos_chip_q == '1) begin
              ovf_q <= 1'b1;
            end else begin
              pos_chip_q <= pos_chip_q + 1'b1;
            end
          end else begin
            pos_chan_q <= pos_chan_q + 1'b1;
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end

      if (frame_close) begin
        frame_ok_q <= frame_good;
        bit_cnt_q  <= '0;  // discard any partial word
      end
    end
  end

  assign word_data   = word_data_q;
  assign word_valid  = word_valid_q;
  assign chan_idx    = chan_idx_q;
  assign chip_idx    = chip_idx_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign frame_ok    = frame_ok_q;
  assign busy        = (state_q == ST_RECV);

endmodule
